// File: rtl/accel_pkg.sv
// Shared types and default widths for the matrix co-accelerator address path.
package accel_pkg;

  localparam int W_AW_DEF  = 6;
  localparam int V_AW_DEF  = 5;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tile_counter.sv
// Nested row/col beat counter for a row-major tile; flags describe the beat
// currently presented, so they are precomputed one step ahead and registered.
module tile_counter
  import accel_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_rows,
  input  logic [CNT_W-1:0] i_cols,
  input  logic             i_en,
  output logic             o_row_last,
  output logic             o_seq_last
);

  logic [CNT_W-1:0] r_rows;
  logic [CNT_W-1:0] r_cols;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_row_last;
  logic             r_seq_last;

  logic [CNT_W-1:0] w_rows_sel;
  logic [CNT_W-1:0] w_cols_sel;
  logic [CNT_W-1:0] w_row_nxt;
  logic [CNT_W-1:0] w_col_nxt;
  logic             w_row_last_nxt;
  logic             w_seq_last_nxt;

  // On load the flags must be derived from the incoming config, not the stale one
  always_comb begin
    w_rows_sel = i_load ? i_rows : r_rows;
    w_cols_sel = i_load ? i_cols : r_cols;
    w_row_nxt  = r_row;
    w_col_nxt  = r_col;
    if (i_load) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (i_en) begin
      if (r_row_last) begin
        w_col_nxt = '0;
        w_row_nxt = r_row + CNT_W'(1);
      end else begin
        w_col_nxt = r_col + CNT_W'(1);
      end
    end
    w_row_last_nxt = (w_col_nxt == (w_cols_sel - CNT_W'(1)));
    w_seq_last_nxt = w_row_last_nxt && (w_row_nxt == (w_rows_sel - CNT_W'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rows     <= '0;
      r_cols     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_row_last <= 1'b0;
      r_seq_last <= 1'b0;
    end else begin
      if (i_load) begin
        r_rows <= i_rows;
        r_cols <= i_cols;
      end
      if (i_load || i_en) begin
        r_row      <= w_row_nxt;
        r_col      <= w_col_nxt;
        r_row_last <= w_row_last_nxt;
        r_seq_last <= w_seq_last_nxt;
      end
    end
  end

  assign o_row_last = r_row_last;
  assign o_seq_last = r_seq_last;

endmodule

// File: rtl/addr_seq_gen.sv
// Walks a rows x cols tile emitting weight/vector SRAM read addresses with a
// valid/ready handshake; weight address advances every beat, vector per column.
module addr_seq_gen
  import accel_pkg::*;
#(
  parameter int W_AW  = W_AW_DEF,
  parameter int V_AW  = V_AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [W_AW-1:0]  i_cfg_w_base,
  input  logic [V_AW-1:0]  i_cfg_v_base,
  input  logic [CNT_W-1:0] i_cfg_rows,
  input  logic [CNT_W-1:0] i_cfg_cols,
  output logic [W_AW-1:0]  o_sram_raddr_w,
  output logic [V_AW-1:0]  o_sram_raddr_v,
  output logic             o_addr_valid,
  input  logic             i_addr_ready,
  output logic             o_row_last,
  output logic             o_seq_last,
  output logic             o_busy,
  output logic             o_done
);

  state_t          r_state;
  logic [W_AW-1:0] r_w_ptr;
  logic [V_AW-1:0] r_v_ptr;
  logic [V_AW-1:0] r_v_base;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;

  logic w_xfer;
  logic w_empty;
  logic w_load;
  logic w_cnt_en;
  logic w_row_last;
  logic w_seq_last;

  assign w_xfer   = r_valid && i_addr_ready;
  assign w_empty  = (i_cfg_rows == '0) || (i_cfg_cols == '0);
  assign w_load   = (r_state == IDLE) && i_start && !w_empty;
  assign w_cnt_en = w_xfer && !w_seq_last;

  tile_counter #(.CNT_W(CNT_W)) u_tile_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_rows     (i_cfg_rows),
    .i_cols     (i_cfg_cols),
    .i_en       (w_cnt_en),
    .o_row_last (w_row_last),
    .o_seq_last (w_seq_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_w_ptr  <= '0;
      r_v_ptr  <= '0;
      r_v_base <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_empty) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= RUN;
              r_valid  <= 1'b1;
              r_w_ptr  <= i_cfg_w_base;
              r_v_ptr  <= i_cfg_v_base;
              r_v_base <= i_cfg_v_base;
            end
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_w_ptr <= r_w_ptr + W_AW'(1);
            r_v_ptr <= w_row_last ? r_v_base : r_v_ptr + V_AW'(1);
            if (w_seq_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sram_raddr_w = r_w_ptr;
  assign o_sram_raddr_v = r_v_ptr;
  assign o_addr_valid   = r_valid;
  // Counter flags linger after the last beat; only meaningful alongside valid
  assign o_row_last     = r_valid && w_row_last;
  assign o_seq_last     = r_valid && w_seq_last;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule
